// File: rtl/ram_rd_pkg.sv
// Shared defaults and FSM state encoding for the RAM stream reader.
// The optional checksum output is selected by defining RAM_RD_CHECKSUM_EN.
package ram_rd_pkg;

    localparam int RD_ADDR_W_DEF = 6;
    localparam int RD_DATA_W_DEF = 8;
    localparam int RD_BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry output buffer between the RAM read pipeline and the stream consumer.
// Handshake: a word moves on a side exactly when its valid and ready are both high at the clock edge.
module rd_skid_fifo
    import ram_rd_pkg::*;
#(
    parameter int DATA_W = RD_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [RD_BUF_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    // A full buffer can still accept when the head leaves in the same cycle.
    assign o_in_ready  = (r_count != 2'(RD_BUF_DEPTH)) || i_out_ready;
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Streams len words from a synchronous-read RAM starting at base_addr, in address order.
// Defining RAM_RD_CHECKSUM_EN adds a per-job checksum output.
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W = RD_ADDR_W_DEF,
    parameter int DATA_W = RD_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef RAM_RD_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output state_t            o_dbg_state
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_left;
    logic              r_issue;
    logic              r_q_pend;
    logic              r_busy;
    logic              r_done;

    logic              w_fifo_in_ready;
    logic [1:0]        w_fifo_count;
    logic              w_wr;
    logic              w_pop;
    logic [1:0]        w_count_next;
    logic              w_can_issue;
    logic              w_drained;

    rd_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (r_q_pend),
        .o_in_ready  (w_fifo_in_ready),
        .i_in_data   (ram_q),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_count     (w_fifo_count)
    );

    // r_issue: ram_addr carries a fresh address this cycle; r_q_pend: ram_q holds an uncaptured word.
    // While no new address is issued the RAM keeps presenting the last word, so it can wait on ram_q.
    assign w_wr         = r_q_pend && w_fifo_in_ready;
    assign w_pop        = out_valid && out_ready;
    assign w_count_next = w_fifo_count + 2'(w_wr) - 2'(w_pop);
    assign w_can_issue  = (w_count_next < 2'(RD_BUF_DEPTH));
    assign w_drained    = (w_count_next == 2'd0) && !r_issue && !r_q_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_left   <= '0;
            r_issue  <= 1'b0;
            r_q_pend <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_issue  <= 1'b0;
            r_q_pend <= r_issue || (r_q_pend && !w_wr);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_state <= READ;
                            r_busy  <= 1'b1;
                            r_addr  <= base_addr;
                            r_left  <= len - (ADDR_W+1)'(1);
                            r_issue <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (r_left == '0) begin
                        r_state <= DRAIN;
                    end else if (w_can_issue) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_left  <= r_left - (ADDR_W+1)'(1);
                        r_issue <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_RD_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (r_state == IDLE && start) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + out_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign ram_addr    = r_addr;
    assign ram_we      = 1'b0;
    assign ram_data    = '0;
    assign o_dbg_state = r_state;

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width (64 words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, captured with start.
REQ-007 SHALL have port len  input  ADDR_W+1  word count 0..64, captured with start.
REQ-008 SHALL have port busy  output  1  transfer in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port ram_addr  output  ADDR_W  address to ram_8bit addr.
REQ-011 SHALL have port ram_we  output  1  to ram_8bit we; always 0.
REQ-012 SHALL have port ram_data  output  DATA_W  to ram_8bit data; always 0.
REQ-013 SHALL have port ram_q  input  DATA_W  from ram_8bit q; valid one cycle after ram_addr is presented.
REQ-014 SHALL have port out_data  output  DATA_W  streamed read word.
REQ-015 SHALL have port out_valid  output  1  out_data valid.
REQ-016 SHALL have port out_ready  input  1  downstream accept; a word transfers on a cycle with out_valid and out_ready both high.

Function
REQ-017 SHALL implement the states IDLE, READ, DRAIN and DONE.
REQ-018 IDLE: start=1 with len>0 SHALL capture base_addr/len and go to READ; with len=0 it SHALL go to DONE directly.
REQ-019 READ SHALL issue one address per cycle (base_addr, base_addr+1, ...), modulo 2^ADDR_W (63 wraps to 0), whenever free output-buffer slots exceed in-flight reads.
REQ-020 READ SHALL go to DRAIN in the cycle after the len-th address is issued.
REQ-021 DRAIN SHALL hold until the buffer is empty and no read is in flight, then go to DONE.
REQ-022 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-023 busy SHALL be 1 in READ and DRAIN only.
REQ-024 Each ram_q word SHALL be written into a 2-entry output buffer on the edge after its address cycle.
REQ-025 Latency: start sampled at edge N SHALL give ram_addr=base_addr after edge N and out_valid=1 after edge N+2.
REQ-026 Throughput: with out_ready held high, one word SHALL transfer per cycle.
REQ-027 Words SHALL be delivered in address order, with no loss or duplication under any out_ready pattern.
REQ-028 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 ram_addr SHALL hold its last value when no read is issued.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, empty the buffer, drop in-flight reads, and clear the address and count registers.
REQ-032 After reset: busy=0, done=0, out_valid=0, out_data=0, ram_addr=0, ram_we=0, ram_data=0.
REQ-033 Reset mid-transfer SHALL abort it without a done pulse; start is first accepted on the edge after rst falls.

Configuration
REQ-034 With macro RAM_RD_CHECKSUM_EN defined, the block SHALL add output checksum[DATA_W-1:0]: the mod-2^DATA_W sum of all words transferred in the current job.
REQ-035 The checksum SHALL be cleared on start acceptance and valid when done=1.
REQ-036 Without RAM_RD_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-037 Package ram_rd_pkg SHALL hold the ADDR_W/DATA_W defaults and the state enum (IDLE, READ, DRAIN, DONE).
REQ-038 The output buffer SHALL be sub-module rd_skid_fifo: 2-entry, valid/ready, with count output.
REQ-039 The FSM, address counter and in-flight tracking SHALL live in ram_stream_reader.

Verification
REQ-040 RAM preloaded 0->01, 1->06, 2->02, 3->04; start base=0 len=4, out_ready=1 -> out_data 01,06,02,04 on 4 consecutive cycles from edge N+2; done one cycle later.
REQ-041 Wrap: mem[62]=AA, mem[63]=BB, mem[0]=01; base=62 len=3 -> AA, BB, 01; ram_addr sequence 62, 63, 0.
REQ-042 Backpressure: test REQ-040 with out_ready toggling 1,0,0,1,0,1... -> same 4 words in order; out_data stable while stalled; at most 2 buffered words.
REQ-043 len=0 -> done pulse one cycle after start, busy never 1, out_valid never 1.
REQ-044 rst during the 2nd word of a len=4 job -> no done pulse, outputs at reset values; a new job base=2 len=2 then gives 02, 04.
REQ-045 With RAM_RD_CHECKSUM_EN, REQ-040 stimulus -> checksum=0x0D when done=1.
